// File: rtl/cmp_pkg.sv
// Shared definitions for the comparison pipeline: opcode encodings and mode type.
package cmp_pkg;

  localparam int unsigned CMP_MODE_W = 3;

  typedef enum logic [CMP_MODE_W-1:0] {
    CMP_SGT  = 3'b000,
    CMP_SLT  = 3'b001,
    CMP_SGE  = 3'b010,
    CMP_SLE  = 3'b011,
    CMP_SEQ  = 3'b100,
    CMP_SNE  = 3'b101,
    CMP_SGTU = 3'b110,
    CMP_SLTU = 3'b111
  } cmp_mode_e;

endpackage

// File: rtl/cmp_core.sv
// Combinational comparator: evaluates one of eight signed/unsigned relations on a, b.
module cmp_core
  import cmp_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  cmp_mode_e        mode,
  output logic             is_true
);

  logic eq;
  logic ult;
  logic slt;

  // Every relation is derived from equality plus one signed and one unsigned less-than.
  always_comb begin
    eq  = (a == b);
    ult = (a < b);
    slt = ($signed(a) < $signed(b));
  end

  always_comb begin
    is_true = 1'b0;
    case (mode)
      CMP_SGT:  is_true = !slt && !eq;
      CMP_SLT:  is_true = slt;
      CMP_SGE:  is_true = !slt;
      CMP_SLE:  is_true = slt || eq;
      CMP_SEQ:  is_true = eq;
      CMP_SNE:  is_true = !eq;
      CMP_SGTU: is_true = !ult && !eq;
      CMP_SLTU: is_true = ult;
      default:  is_true = 1'b0;
    endcase
  end

endmodule

// File: rtl/cmp_pipe.sv
// Two-stage valid/ready comparison pipeline with a saturating true-result counter.
module cmp_pipe
  import cmp_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [CMP_MODE_W-1:0] in_mode,
  input  logic [WIDTH-1:0]      in_a,
  input  logic [WIDTH-1:0]      in_b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out_result,
  output logic                  out_flag,
  output logic [CNT_W-1:0]      true_count,
  input  logic                  count_clr
);

  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] s1_a_q, s1_a_d;
  logic [WIDTH-1:0] s1_b_q, s1_b_d;
  cmp_mode_e        s1_mode_q, s1_mode_d;

  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0] s2_result_q, s2_result_d;
  logic             s2_flag_q, s2_flag_d;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic s1_adv;
  logic s2_adv;
  logic in_xfer;
  logic out_xfer;
  logic cmp_true;

  always_comb begin
    s2_adv   = !s2_valid_q || out_ready;
    s1_adv   = !s1_valid_q || s2_adv;
    in_xfer  = in_valid && s1_adv;
    out_xfer = s2_valid_q && out_ready;
  end

  assign in_ready = s1_adv;

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_mode_d  = s1_mode_q;
    if (s1_adv) begin
      s1_valid_d = in_valid;
    end
    if (in_xfer) begin
      s1_a_d    = in_a;
      s1_b_d    = in_b;
      s1_mode_d = cmp_mode_e'(in_mode);
    end
  end

  cmp_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .a       (s1_a_q),
    .b       (s1_b_q),
    .mode    (s1_mode_q),
    .is_true (cmp_true)
  );

  // The result/flag pair only reloads when a new operand set moves in, so the
  // flag always describes the result it is registered with.
  always_comb begin
    s2_valid_d  = s2_valid_q;
    s2_result_d = s2_result_q;
    s2_flag_d   = s2_flag_q;
    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_result_d = {WIDTH{cmp_true}};
        s2_flag_d   = !cmp_true;
      end
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (count_clr) begin
      cnt_d = '0;
    end else if (out_xfer && !s2_flag_q && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      s1_mode_q   <= CMP_SGT;
      s2_valid_q  <= 1'b0;
      s2_result_q <= '0;
      s2_flag_q   <= 1'b1;
      cnt_q       <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_a_q      <= s1_a_d;
      s1_b_q      <= s1_b_d;
      s1_mode_q   <= s1_mode_d;
      s2_valid_q  <= s2_valid_d;
      s2_result_q <= s2_result_d;
      s2_flag_q   <= s2_flag_d;
      cnt_q       <= cnt_d;
    end
  end

  assign out_valid  = s2_valid_q;
  assign out_result = s2_result_q;
  assign out_flag   = s2_flag_q;
  assign true_count = cnt_q;

endmodule

// File: tb/tb_cmp_pipe.sv
// Self-checking bench for cmp_pipe: directed vectors plus a queue-based reference model.
module tb_cmp_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [2:0]  in_mode;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        out_ready;
  logic        count_clr;

  logic        in_ready, out_valid, out_flag;
  logic [31:0] out_result;
  logic [15:0] true_count;

  logic        in_ready2, out_valid2, out_flag2;
  logic [31:0] out_result2;
  logic [1:0]  true_count2;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  cmp_pipe #(
    .WIDTH (32),
    .CNT_W (16)
  ) u_dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_mode    (in_mode),
    .in_a       (in_a),
    .in_b       (in_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_flag   (out_flag),
    .true_count (true_count),
    .count_clr  (count_clr)
  );

  cmp_pipe #(
    .WIDTH (32),
    .CNT_W (2)
  ) u_dut2 (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready2),
    .in_mode    (in_mode),
    .in_a       (in_a),
    .in_b       (in_b),
    .out_valid  (out_valid2),
    .out_ready  (out_ready),
    .out_result (out_result2),
    .out_flag   (out_flag2),
    .true_count (true_count2),
    .count_clr  (count_clr)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference relation evaluated with plain integer arithmetic.
  function automatic bit model_true(input logic [2:0] m, input logic [31:0] a, input logic [31:0] b);
    longint ua, ub, sa, sb;
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    sa = a[31] ? ua - (longint'(1) << 32) : ua;
    sb = b[31] ? ub - (longint'(1) << 32) : ub;
    case (m)
      3'd0: return sa > sb;
      3'd1: return sa < sb;
      3'd2: return sa >= sb;
      3'd3: return sa <= sb;
      3'd4: return ua == ub;
      3'd5: return ua != ub;
      3'd6: return ua > ub;
      default: return ua < ub;
    endcase
  endfunction

  bit          q_exp[$];
  longint      cnt1, cnt2;
  bit          hold_pend;
  logic [31:0] held;
  bit          model_on = 1'b0;

  // Inputs change just after the rising edge, so the falling edge sees the
  // values that the next rising edge will act on.
  always @(negedge clk) begin
    bit exp_t;
    int occ;
    if (rst) begin
      q_exp.delete();
      cnt1      = 0;
      cnt2      = 0;
      hold_pend = 1'b0;
    end else if (model_on) begin
      occ = q_exp.size();
      check("in_ready", in_ready, (occ < 2) || out_ready);
      check("in_ready_w2", in_ready2, (occ < 2) || out_ready);
      check("flag_consistency", out_flag, out_result == 32'd0);
      check("true_count", true_count, cnt1);
      check("true_count_w2", true_count2, cnt2);
      if (hold_pend) begin
        check("hold_result", out_result, held);
        check("hold_valid", out_valid, 1);
      end
      hold_pend = out_valid && !out_ready;
      held      = out_result;
      if (out_valid && out_ready) begin
        if (occ == 0) begin
          check("unexpected_output", out_valid, 0);
        end else begin
          exp_t = q_exp.pop_front();
          check("result", out_result, {32{exp_t}});
          check("flag", out_flag, !exp_t);
          check("result_w2", out_result2, {32{exp_t}});
          if (exp_t) begin
            if (cnt1 < 65535) cnt1++;
            if (cnt2 < 3) cnt2++;
          end
        end
      end
      if (count_clr) begin
        cnt1 = 0;
        cnt2 = 0;
      end
      if (in_valid && in_ready) q_exp.push_back(model_true(in_mode, in_a, in_b));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] m, input logic [31:0] a, input logic [31:0] b);
    in_valid = 1'b1;
    in_mode  = m;
    in_a     = a;
    in_b     = b;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int          out_k[$];
    logic [31:0] out_v[$];
    logic [7:0]  pat;
    logic [2:0]  it_m[3];
    logic [31:0] it_a[3];
    logic [31:0] it_b[3];
    int          j, acc;
    bit          acc_now;

    rst = 1'b1; in_valid = 1'b0; in_mode = '0; in_a = '0; in_b = '0;
    out_ready = 1'b1; count_clr = 1'b0;
    repeat (3) step();
    check("reset_out_valid", out_valid, 0);
    check("reset_out_flag", out_flag, 1);
    check("reset_out_result", out_result, 0);
    check("reset_true_count", true_count, 0);
    check("reset_true_count_w2", true_count2, 0);
    rst = 1'b0;
    model_on = 1'b1;
    check("in_ready_after_reset", in_ready, 1);

    // Latency and signed/unsigned distinction on the same operands.
    drive(3'd0, 32'hFFFF_FFFF, 32'h0000_0001);
    step();
    in_valid = 1'b0;
    check("latency_not_early", out_valid, 0);
    step();
    check("latency_valid", out_valid, 1);
    check("sgt_neg_result", out_result, 32'h0);
    check("sgt_neg_flag", out_flag, 1);
    drive(3'd6, 32'hFFFF_FFFF, 32'h0000_0001);
    step();
    in_valid = 1'b0;
    check("latency_not_early2", out_valid, 0);
    step();
    check("latency_valid2", out_valid, 1);
    check("sgtu_result", out_result, 32'hFFFF_FFFF);
    check("sgtu_flag", out_flag, 0);
    repeat (2) step();

    // All eight modes back-to-back on the sign boundary.
    count_clr = 1'b1;
    step();
    count_clr = 1'b0;
    pat = 8'b0110_1010;
    for (int k = 0; k < 12; k++) begin
      if (k < 8) drive(3'(k), 32'h8000_0000, 32'h7FFF_FFFF);
      else in_valid = 1'b0;
      step();
      if (out_valid) begin
        out_k.push_back(k);
        out_v.push_back(out_result);
      end
    end
    check("stream_count", out_v.size(), 8);
    for (int i = 0; i < out_v.size(); i++) begin
      check("stream_result", out_v[i], {32{pat[i]}});
      check("stream_cycle", out_k[i], i + 1);
    end
    check("stream_true_count", true_count, 4);
    check("stream_true_count_w2", true_count2, 3);

    // Backpressure: only two operand sets fit while the output is stalled.
    it_m[0] = 3'd4; it_a[0] = 32'd7; it_b[0] = 32'd7;
    it_m[1] = 3'd5; it_a[1] = 32'd7; it_b[1] = 32'd7;
    it_m[2] = 3'd0; it_a[2] = 32'd9; it_b[2] = 32'd1;
    out_ready = 1'b0;
    j = 0; acc = 0;
    repeat (5) begin
      drive(it_m[j], it_a[j], it_b[j]);
      acc_now = in_ready;
      step();
      if (acc_now) begin
        acc++;
        if (j < 2) j++;
      end
    end
    check("bp_accepted", acc, 2);
    check("bp_in_ready_low", in_ready, 0);
    check("bp_out_valid", out_valid, 1);
    check("bp_held_result", out_result, 32'hFFFF_FFFF);
    in_valid = 1'b0;
    out_ready = 1'b1;
    out_v.delete();
    repeat (4) begin
      if (out_valid) out_v.push_back(out_result);
      step();
    end
    check("bp_release_count", out_v.size(), 2);
    if (out_v.size() == 2) begin
      check("bp_release_first", out_v[0], 32'hFFFF_FFFF);
      check("bp_release_second", out_v[1], 32'h0);
    end

    // Saturation of the narrow counter and clear winning over increment.
    count_clr = 1'b1;
    step();
    count_clr = 1'b0;
    for (int k = 0; k < 5; k++) begin
      drive(3'd4, 32'(k), 32'(k));
      step();
    end
    in_valid = 1'b0;
    repeat (4) step();
    check("sat_true_count", true_count, 5);
    check("sat_true_count_w2", true_count2, 3);
    drive(3'd4, 32'd1, 32'd1);
    step();
    in_valid = 1'b0;
    step();
    check("clr_pending_valid", out_valid, 1);
    count_clr = 1'b1;
    step();
    count_clr = 1'b0;
    check("clr_wins", true_count, 0);
    check("clr_wins_w2", true_count2, 0);

    // Asynchronous reset with both stages occupied.
    drive(3'd4, 32'd2, 32'd2);
    step();
    in_valid = 1'b0;
    repeat (3) step();
    check("pre_reset_count", true_count, 1);
    out_ready = 1'b0;
    drive(3'd6, 32'd5, 32'd1);
    step();
    drive(3'd6, 32'd6, 32'd1);
    step();
    in_valid = 1'b0;
    check("full_out_valid", out_valid, 1);
    check("full_in_ready", in_ready, 0);
    rst = 1'b1;
    #1;
    check("async_rst_out_valid", out_valid, 0);
    check("async_rst_out_flag", out_flag, 1);
    check("async_rst_out_result", out_result, 0);
    check("async_rst_true_count", true_count, 0);
    check("async_rst_out_valid_w2", out_valid2, 0);
    check("async_rst_out_flag_w2", out_flag2, 1);
    step();
    step();
    rst = 1'b0;
    check("in_ready_after_rst_pulse", in_ready, 1);
    out_ready = 1'b1;
    repeat (6) begin
      step();
      check("no_stale_after_rst", out_valid, 0);
    end

    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
